// File: rtl/single_matrix_loader.sv
// Stream-to-matrix assembler: packs a valid/ready word stream into a WIDTH x HEIGHT
// array and hands the whole array on under a matrix-level valid/ready handshake.
module single_matrix_loader #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    localparam int CW    = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   m_out [WIDTH][HEIGHT],
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] fill_count
);

    localparam int IW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int JW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int NUM = WIDTH * HEIGHT;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [CW-1:0] fill_q, fill_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   mat_q [WIDTH][HEIGHT];
    logic          accept_s;
    logic          last_s;

    // Ready depends only on state (and reset), never on in_valid.
    always_comb begin
        in_ready = (state_q == ST_LOAD) && !rst;
        accept_s = in_valid && in_ready;
        last_s   = (fill_q == CW'(NUM - 1));
    end

    // Next-state logic: row-major fill (j fast), then hold until the consumer takes it.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        fill_d    = fill_q;
        m_valid_d = m_valid_q;
        case (state_q)
            ST_LOAD: begin
                m_valid_d = 1'b0;
                if (accept_s) begin
                    fill_d = fill_q + CW'(1);
                    if (last_s) begin
                        i_d       = IW'(0);
                        j_d       = JW'(0);
                        state_d   = ST_FULL;
                        m_valid_d = 1'b1;
                    end else if (j_q == JW'(HEIGHT - 1)) begin
                        j_d = JW'(0);
                        i_d = i_q + IW'(1);
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end else begin
                    fill_d = fill_q;
                end
            end
            ST_FULL: begin
                if (m_ready) begin
                    state_d   = ST_LOAD;
                    m_valid_d = 1'b0;
                    fill_d    = CW'(0);
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d   = ST_LOAD;
                m_valid_d = 1'b0;
                fill_d    = CW'(0);
                i_d       = IW'(0);
                j_d       = JW'(0);
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            i_q       <= IW'(0);
            j_q       <= JW'(0);
            fill_q    <= CW'(0);
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            fill_q    <= fill_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Element storage; contents survive handoff and are overwritten as the next matrix loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < WIDTH; r++) begin
                for (int c = 0; c < HEIGHT; c++) begin
                    mat_q[r][c] <= 32'h0000_0000;
                end
            end
        end else if (accept_s) begin
            mat_q[i_q][j_q] <= in_data;
        end
    end

    assign m_out      = mat_q;
    assign m_valid    = m_valid_q;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_single_matrix_loader.sv
// Self-checking bench: a 2x3 and a 1x1 loader share one stimulus stream and are
// compared every cycle against an element-index model, plus literal scenario checks.
module tb_single_matrix_loader;

    localparam int W = 2;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst, in_valid, m_ready;
    logic [31:0] in_data;
    logic        in_ready, m_valid;
    logic [31:0] m_out [W][H];
    logic [2:0]  fill_count;
    logic        in_ready1, m_valid1;
    logic [31:0] m_out1 [1][1];
    logic [0:0]  fill_count1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    single_matrix_loader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .m_out(m_out), .m_valid(m_valid), .m_ready(m_ready), .fill_count(fill_count)
    );

    single_matrix_loader #(.WIDTH(1), .HEIGHT(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .m_out(m_out1), .m_valid(m_valid1), .m_ready(m_ready), .fill_count(fill_count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: element k of the current matrix lives at flat index k.
    logic [31:0] exp_flat [N];
    int          cnt;
    bit          full;
    logic [31:0] exp1;
    int          cnt1;
    bit          full1;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) exp_flat[k] = 32'h0;
            cnt = 0; full = 1'b0;
            exp1 = 32'h0; cnt1 = 0; full1 = 1'b0;
        end else begin
            if (full) begin
                if (m_ready) begin full = 1'b0; cnt = 0; end
            end else if (in_valid) begin
                exp_flat[cnt] = in_data;
                cnt++;
                if (cnt == N) full = 1'b1;
            end
            if (full1) begin
                if (m_ready) begin full1 = 1'b0; cnt1 = 0; end
            end else if (in_valid) begin
                exp1 = in_data; cnt1 = 1; full1 = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 32'(in_ready), 32'(!full && !rst));
            chk("m_valid", 32'(m_valid), 32'(full));
            chk("fill_count", 32'(fill_count), 32'(cnt));
            for (int r = 0; r < W; r++)
                for (int c = 0; c < H; c++)
                    chk($sformatf("m_out[%0d][%0d]", r, c), m_out[r][c], exp_flat[r*H+c]);
            chk("in_ready1", 32'(in_ready1), 32'(!full1 && !rst));
            chk("m_valid1", 32'(m_valid1), 32'(full1));
            chk("fill_count1", 32'(fill_count1), 32'(cnt1));
            chk("m_out1", m_out1[0][0], exp1);
        end
    end

    task automatic check_mat(input int base);
        for (int r = 0; r < W; r++)
            for (int c = 0; c < H; c++)
                chk($sformatf("lit%0d[%0d][%0d]", base, r, c), m_out[r][c], 32'(base + r*H + c));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic handoff();
        m_ready = 1'b1;
        edge_step();
        m_ready = 1'b0;
    endtask

    int accepted, rises, mv_cyc, low;
    bit prev_mv, acc;

    task automatic observe();
        @(negedge clk);
        if (m_valid) begin
            mv_cyc++;
            if (!prev_mv) begin
                rises++;
                check_mat(rises == 1 ? 41 : 47);
            end
        end
        prev_mv = m_valid;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; m_ready = 1'b0; in_data = 32'h0;
        edge_step();
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_fill", 32'(fill_count), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        edge_step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Continuous load of 1..6
        edge_step();
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1; in_data = 32'(k);
            @(negedge clk);
            if (k == 6) chk("mv_before_last", 32'(m_valid), 32'd0);
            edge_step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mv_after_last", 32'(m_valid), 32'd1);
        chk("fill_full", 32'(fill_count), 32'd6);
        chk("ready_full", 32'(in_ready), 32'd0);
        check_mat(1);

        // Backpressure with in_valid asserted
        edge_step();
        in_valid = 1'b1; in_data = 32'h4000_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_mvalid", 32'(m_valid), 32'd1);
            chk("bp_hold", m_out[1][2], 32'd6);
            edge_step();
        end
        handoff();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ho_mvalid", 32'(m_valid), 32'd0);
        chk("ho_ready", 32'(in_ready), 32'd1);
        chk("ho_keep", m_out[0][0], 32'd1);
        chk("ho_fill", 32'(fill_count), 32'd0);

        // Gapped input 21..26, pattern 1,0,0
        edge_step();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 32'(21 + k);
            edge_step();
            in_valid = 1'b0; in_data = $urandom;
            @(negedge clk);
            chk("gap_fill", 32'(fill_count), 32'(k + 1));
            edge_step();
            edge_step();
        end
        check_mat(21);
        handoff();

        // Reset mid-load
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 32'(31 + k);
            edge_step();
        end
        rst = 1'b1; in_data = 32'd34;
        edge_step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_mat_zero();
        chk("rst_mid_fill", 32'(fill_count), 32'd0);
        edge_step();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 32'(11 + k);
            edge_step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_mat(11);
        edge_step();
        handoff();

        // Back-to-back with m_ready tied high
        m_ready = 1'b1; in_valid = 1'b1;
        accepted = 0; rises = 0; mv_cyc = 0; low = 0; prev_mv = 1'b0;
        for (int cyc = 0; cyc < 40 && accepted < 12; cyc++) begin
            in_data = 32'(41 + accepted);
            observe();
            if (!in_ready) low++;
            acc = !full && !rst;
            edge_step();
            if (acc) accepted++;
        end
        in_valid = 1'b0;
        repeat (3) observe();
        edge_step();
        m_ready = 1'b0;
        chk("b2b_accepted", 32'(accepted), 32'd12);
        chk("b2b_rises", 32'(rises), 32'd2);
        chk("b2b_mv_cycles", 32'(mv_cyc), 32'd2);
        chk("b2b_bubble", 32'(low), 32'd1);

        // 1x1 single accept
        rst = 1'b1;
        edge_step();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("one_data", m_out1[0][0], 32'h3F80_0000);
        chk("one_mvalid", 32'(m_valid1), 32'd1);
        chk("one_fill", 32'(fill_count1), 32'd1);
        edge_step();
        handoff();

        // Randomized traffic
        repeat (400) begin
            rst      = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            m_ready  = $urandom_range(0, 1) == 1;
            in_data  = $urandom;
            edge_step();
        end
        rst = 1'b0; in_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic check_mat_zero();
        for (int r = 0; r < W; r++)
            for (int c = 0; c < H; c++)
                chk($sformatf("zero[%0d][%0d]", r, c), m_out[r][c], 32'h0);
    endtask

endmodule
